// File: rtl/comb_gates_pairwise_pkg.sv
// Shared constants for the pairwise gate array.
package comb_gates_pairwise_pkg;

  // Default input vector width; outputs are one bit narrower.
  localparam int unsigned DEFAULT_WIDTH = 100;

endpackage : comb_gates_pairwise_pkg

// File: rtl/comb_gates_pair_cell.sv
// Single neighbour-pair cell: AND, OR and XNOR of two adjacent input bits.
module comb_gates_pair_cell (
  input  logic a_in,
  input  logic b_in,
  output logic and_out,
  output logic or_out,
  output logic xnor_out
);

  // Plain 4-state gate semantics, no special handling of X/Z.
  always_comb begin
    and_out  = a_in & b_in;
    or_out   = a_in | b_in;
    xnor_out = ~(a_in ^ b_in);
  end

endmodule : comb_gates_pair_cell

// File: rtl/comb_gates_pairwise.sv
// Pairwise gate array: output bit i combines in_[i] and in_[i+1]; there is no
// wrap-around from the top bit to bit 0. Adds any_and / all_eq reduction flags.
// Optional feature macro COMB_GATES_PAIRWISE_OUT_REG_EN registers all outputs
// (1-cycle latency, asynchronous active-low clear). Without it the block is
// purely combinational and clk/reset are unused.
module comb_gates_pairwise
  import comb_gates_pairwise_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_,
  output logic [WIDTH-2:0] out_and,
  output logic [WIDTH-2:0] out_or,
  output logic [WIDTH-2:0] out_xnor,
  output logic             any_and,
  output logic             all_eq
);

  logic [WIDTH-2:0] out_and_d;
  logic [WIDTH-2:0] out_or_d;
  logic [WIDTH-2:0] out_xnor_d;
  logic             any_and_d;
  logic             all_eq_d;

  // One cell per adjacent pair; cell gi pairs in_[gi] with in_[gi+1].
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_pair
    comb_gates_pair_cell u_cell (
      .a_in     (in_[gi]),
      .b_in     (in_[gi+1]),
      .and_out  (out_and_d[gi]),
      .or_out   (out_or_d[gi]),
      .xnor_out (out_xnor_d[gi])
    );
  end

  // Reduction flags: some pair both set, and every pair equal (all bits equal).
  always_comb begin
    any_and_d = |out_and_d;
    all_eq_d  = &out_xnor_d;
  end

`ifdef COMB_GATES_PAIRWISE_OUT_REG_EN
  logic [WIDTH-2:0] out_and_q;
  logic [WIDTH-2:0] out_or_q;
  logic [WIDTH-2:0] out_xnor_q;
  logic             any_and_q;
  logic             all_eq_q;

  // Output register stage; reset low clears every output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_and_q  <= '0;
      out_or_q   <= '0;
      out_xnor_q <= '0;
      any_and_q  <= 1'b0;
      all_eq_q   <= 1'b0;
    end else begin
      out_and_q  <= out_and_d;
      out_or_q   <= out_or_d;
      out_xnor_q <= out_xnor_d;
      any_and_q  <= any_and_d;
      all_eq_q   <= all_eq_d;
    end
  end

  assign out_and  = out_and_q;
  assign out_or   = out_or_q;
  assign out_xnor = out_xnor_q;
  assign any_and  = any_and_q;
  assign all_eq   = all_eq_q;
`else
  // Clock and reset only matter for the registered build.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign out_and  = out_and_d;
  assign out_or   = out_or_d;
  assign out_xnor = out_xnor_d;
  assign any_and  = any_and_d;
  assign all_eq   = all_eq_d;
`endif

endmodule : comb_gates_pairwise

// File: tb/tb_comb_gates_pairwise.sv
// Self-checking bench for comb_gates_pairwise (WIDTH=100). Expected results are
// queued when in_ is driven and popped when the DUT output is due. Handles both
// the combinational build and the COMB_GATES_PAIRWISE_OUT_REG_EN build.
module tb_comb_gates_pairwise;

  localparam int W = 100;

  typedef struct {
    logic [W-2:0] e_and;
    logic [W-2:0] e_or;
    logic [W-2:0] e_xnor;
    logic         e_any;
    logic         e_eq;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_;
  logic [W-2:0] out_and;
  logic [W-2:0] out_or;
  logic [W-2:0] out_xnor;
  logic         any_and;
  logic         all_eq;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  comb_gates_pairwise #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_      (in_),
    .out_and  (out_and),
    .out_or   (out_or),
    .out_xnor (out_xnor),
    .any_and  (any_and),
    .all_eq   (all_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-2:0] obs,
                           input logic [W-2:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the per-pair definition.
  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    for (int i = 0; i < W - 1; i++) begin
      e.e_and[i]  = v[i] & v[i+1];
      e.e_or[i]   = v[i] | v[i+1];
      e.e_xnor[i] = (v[i] == v[i+1]);
    end
    e.e_any = 1'b0;
    e.e_eq  = 1'b1;
    for (int i = 0; i < W - 1; i++) begin
      if (e.e_and[i])   e.e_any = 1'b1;
      if (!e.e_xnor[i]) e.e_eq  = 1'b0;
    end
    return e;
  endfunction

  // Drive a vector, queue its expectation, wait for the result, compare.
  task automatic apply(input string tag, input logic [W-1:0] v);
    exp_t e;
    in_ = v;
    sb_q.push_back(model(v));
`ifdef COMB_GATES_PAIRWISE_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, '1, '0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_and"},  out_and,  e.e_and);
      check_val({tag, "_or"},   out_or,   e.e_or);
      check_val({tag, "_xnor"}, out_xnor, e.e_xnor);
      check_val({tag, "_any"},  {{(W-2){1'b0}}, any_and}, {{(W-2){1'b0}}, e.e_any});
      check_val({tag, "_eq"},   {{(W-2){1'b0}}, all_eq},  {{(W-2){1'b0}}, e.e_eq});
    end
    $display("txn %s in=%h and=%h or=%h xnor=%h any=%b eq=%b",
             tag, v, out_and, out_or, out_xnor, any_and, all_eq);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  logic [W-2:0] ones99;
  logic [W-2:0] zero99;
  logic [W-1:0] v;

  initial begin
    ones99 = '1;
    zero99 = '0;
    reset  = 1'b0;
    in_    = '0;
    #2;
`ifdef COMB_GATES_PAIRWISE_OUT_REG_EN
    // Reset state: everything cleared.
    check_val("rst_and",  out_and,  zero99);
    check_val("rst_xnor", out_xnor, zero99);
    check_val("rst_eq",   {{(W-2){1'b0}}, all_eq}, zero99);
`else
    // Reset has no effect: outputs follow in_ (all zero) while reset is low.
    check_val("rst_and",  out_and,  zero99);
    check_val("rst_xnor", out_xnor, ones99);
    check_val("rst_eq",   {{(W-2){1'b0}}, all_eq}, {{(W-2){1'b0}}, 1'b1});
`endif
    @(negedge clk);
    reset = 1'b1;

    apply("zero", '0);
    check_val("zero_xnor_const", out_xnor, ones99);
    apply("ones", '1);
    check_val("ones_and_const", out_and, ones99);
    apply("alt5", 100'h5_5555_5555_5555_5555_5555_5555);
    check_val("alt5_or_const", out_or, ones99);
    apply("altA", 100'hA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    apply("bit0", 100'h1);
    check_val("bit0_or_const", out_or, 99'h1);
    v = '0; v[W-1] = 1'b1;
    apply("bit99", v);
    check_val("bit99_xnor_const", out_xnor, ones99 ^ (99'h1 << 98));
    apply("pair_top", 100'hC_0000_0000_0000_0000_0000_0000);
    apply("pair_low", 100'h3);
    apply("dead", 100'h8_dead_beef_dead_beef_dead_beef);
    for (int i = 0; i < 24; i++) apply($sformatf("rnd%0d", i), rand_vec());

`ifdef COMB_GATES_PAIRWISE_OUT_REG_EN
    // Mid-cycle reset clears outputs without a clock edge.
    in_ = '1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("midrst_and",  out_and,  zero99);
    check_val("midrst_or",   out_or,   zero99);
    check_val("midrst_xnor", out_xnor, zero99);
    check_val("midrst_flags", {{(W-3){1'b0}}, any_and, all_eq}, zero99);
    @(negedge clk);
    reset = 1'b1;
    apply("post_rst_zero", '0);
`else
    // Reset low mid-run is ignored in the combinational build.
    reset = 1'b0;
    apply("rst_low_ones", '1);
    apply("rst_low_rnd", rand_vec());
    reset = 1'b1;
`endif

    check_val("sb_drained", {{(W-2-32){1'b0}}, 32'(sb_q.size())}, zero99);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_comb_gates_pairwise

// File: doc/comb_gates_pairwise.md
Name: comb_gates_pairwise

Overview:
- Pairwise logic-gate array over a WIDTH-bit input vector.
- Each output bit i combines adjacent input bits in_[i] and in_[i+1] with AND, OR and XNOR.
- Adds reduction status flags.
- Leaf datapath block, used wherever neighbour-bit comparisons are needed (edge or run detection, equality scans).

Parameters:
- WIDTH, 100, input vector width; must be >= 2; output vectors are WIDTH-1 bits.

Ports:
- clk  input  1  clock; used only by the optional output register stage.
- reset  input  1  asynchronous, active-low reset; used only by the optional output register stage.
- in_  input  WIDTH  input vector.
- out_and  output  WIDTH-1  bit i = in_[i] & in_[i+1].
- out_or  output  WIDTH-1  bit i = in_[i] | in_[i+1].
- out_xnor  output  WIDTH-1  bit i = ~(in_[i] ^ in_[i+1]).
- any_and  output  1  OR-reduction of out_and (some adjacent pair is both 1).
- all_eq  output  1  AND-reduction of out_xnor (all input bits equal).

Behaviour:
- Default build is purely combinational: zero latency, outputs follow in_ within the same evaluation.
- In the default build, clk and reset have no effect.
- Index mapping is fixed: output bit 0 pairs in_[0]/in_[1]; output bit WIDTH-2 pairs in_[WIDTH-2]/in_[WIDTH-1].
- No wrap-around: in_[WIDTH-1] is never paired with in_[0].
- No X-propagation special casing; the block is standard 4-state gate semantics.
- Boundary cases:
  - in_ all 0 -> out_and=0, out_or=0, out_xnor=all 1, any_and=0, all_eq=1.
  - in_ all 1 -> all three vectors all 1, any_and=1, all_eq=1.
- WIDTH=2 yields single-bit outputs; the reductions equal those single bits.
- No state, handshake or state machine in the default build.

Optional Feature:
- Macro: COMB_GATES_PAIRWISE_OUT_REG_EN.
- Defined: all five outputs are registered on the rising edge of clk, so latency is 1 cycle.
  - Asserting reset (low) asynchronously clears out_and, out_or, out_xnor, any_and and all_eq to 0.
  - Reset release takes effect at the next clk edge, which captures the current in_.
  - Reset asserted mid-operation clears outputs immediately, regardless of clk.
- Undefined: fully combinational as described above; clk and reset are unused.

Decomposition:
- No shared package needed; WIDTH is the only constant.
- One natural sub-module: comb_gates_pair_cell, a single-pair cell taking 2 bits and producing and/or/xnor.
  - Instantiate it WIDTH-1 times via a generate loop.
  - Reductions and the optional register stage live in the top level.

Test Plan:
- in_=100'h0 -> out_and=0, out_or=0, out_xnor=99'h7_ffff_ffff_ffff_ffff_ffff_ffff, any_and=0, all_eq=1.
- in_=100'hf_ffff_ffff_ffff_ffff_ffff_ffff -> out_and=out_or=out_xnor=99'h7_ffff_ffff_ffff_ffff_ffff_ffff, any_and=1, all_eq=1.
- in_=100'h5_5555_5555_5555_5555_5555_5555 (alternating bits) -> out_and=0, out_or=all 1, out_xnor=0, any_and=0, all_eq=0.
- in_=100'h1 -> out_and=0, out_or=99'h1, out_xnor=all 1 except bit 0; in_=1<<99 -> out_or=1<<98, out_xnor bit 98=0, others 1.
- 20+ random in_ (e.g. 100'h8_dead_beef_dead_beef_dead_beef, then $urandom-built) -> every bit matches the per-pair AND/OR/XNOR model; reductions match.
- With COMB_GATES_PAIRWISE_OUT_REG_EN:
  - Drive reset low mid-run -> all outputs 0 immediately.
  - Release reset, apply in_=100'h0 -> after one clk edge out_xnor=all 1, all_eq=1.
